// File: rtl/ps2_sensor_tracker.sv
// Tracks PS/2 set-2 make/break scan codes into a per-channel "key held" mask,
// with popcount, change pulse and sequence-error pulse.
module ps2_sensor_tracker #(
  parameter int unsigned           N_CH      = 4,
  parameter logic [N_CH*8-1:0]     KEY_CODES = {8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter logic [7:0]            CLR_CODE  = 8'h29,
  parameter int unsigned           TO_CYCLES = 1_000_000,
  localparam int unsigned          CW        = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  input  logic            clear,
  output logic [N_CH-1:0] sensor_mask,
  output logic [CW-1:0]   active_count,
  output logic            changed,
  output logic            seq_err
);

  localparam int unsigned TW       = $clog2(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
  localparam logic [7:0]  BRK_CODE = 8'hF0;
  localparam logic [7:0]  EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic            changed_q, changed_d;
  logic            seq_err_q, seq_err_d;
  logic [N_CH-1:0] hit_oh;
  logic            found;
  logic            is_prefix;

  assign is_prefix = (rx_data == BRK_CODE) || (rx_data == EXT_CODE);

  // One-hot of the lowest channel whose key code matches the current byte.
  always_comb begin
    hit_oh = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && rx_data == KEY_CODES[8*i +: 8]) begin
        hit_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_err_d = 1'b0;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == BRK_CODE) begin
            state_d = StBrk;
            cnt_d   = '0;
          end else if (rx_data == EXT_CODE) begin
            state_d = StExt;
            cnt_d   = '0;
          end
        end
        StBrk: begin
          state_d   = StIdle;
          seq_err_d = is_prefix;
        end
        StExt: begin
          if (rx_data == BRK_CODE) begin
            state_d = StExtBrk;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
        StExtBrk: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Silent cycles inside a prefix: abandon it once the budget is spent.
      if (cnt_q == TO_LAST) begin
        state_d   = StIdle;
        cnt_d     = '0;
        seq_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (clear) begin
      mask_d = '0;
    end else if (rx_valid && !is_prefix) begin
      if (state_q == StIdle) begin
        if (rx_data == CLR_CODE) mask_d = '0;
        else                     mask_d = mask_q | hit_oh;
      end else if (state_q == StBrk) begin
        mask_d = mask_q & ~hit_oh;
      end
    end
    changed_d = (mask_d != mask_q);
  end

  always_comb begin
    active_count = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      active_count = active_count + CW'(mask_q[i]);
    end
  end

  assign sensor_mask = mask_q;
  assign changed     = changed_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_ps2_sensor_tracker.sv
// Bench for ps2_sensor_tracker: vector table, hand-written corner sequences,
// randomized traffic against a prefix-queue reference model, and N_CH=1/8 sweeps.
module tb_ps2_sensor_tracker;

  localparam int TO = 8;
  localparam logic [7:0] CLR = 8'h29;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid, clear;
  logic [7:0] rx_data;
  logic [3:0] mask;
  logic [2:0] cnt;
  logic       chg, err;

  logic       v1, v8;
  logic [7:0] d1, d8;
  logic [0:0] mask1, cnt1;
  logic       chg1, err1;
  logic [7:0] mask8;
  logic [3:0] cnt8;
  logic       chg8, err8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ps2_sensor_tracker #(.TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .clear(clear),
    .sensor_mask(mask), .active_count(cnt), .changed(chg), .seq_err(err)
  );

  ps2_sensor_tracker #(.N_CH(1), .KEY_CODES(8'h1C), .TO_CYCLES(TO)) dut1 (
    .clk(clk), .reset(reset), .rx_valid(v1), .rx_data(d1), .clear(clear),
    .sensor_mask(mask1), .active_count(cnt1), .changed(chg1), .seq_err(err1)
  );

  ps2_sensor_tracker #(
    .N_CH(8),
    .KEY_CODES({8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43}),
    .TO_CYCLES(TO)
  ) dut8 (
    .clk(clk), .reset(reset), .rx_valid(v8), .rx_data(d8), .clear(clear),
    .sensor_mask(mask8), .active_count(cnt8), .changed(chg8), .seq_err(err8)
  );

  // Reference model: pending prefix bytes kept in a queue, mask as plain bits.
  logic [7:0] keys[4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [7:0] pend[$];
  logic [3:0] m_mask;
  logic       m_chg, m_err;
  int         idle_cnt;

  function automatic int key_index(input logic [7:0] d);
    for (int i = 0; i < 4; i++) if (keys[i] == d) return i;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_mask = '0; m_chg = 1'b0; m_err = 1'b0; idle_cnt = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input logic [7:0] d);
    logic [3:0] old;
    int k;
    old = m_mask;
    m_err = 1'b0;
    k = key_index(d);
    if (c) begin
      pend.delete(); idle_cnt = 0; m_mask = '0;
    end else if (v) begin
      idle_cnt = 0;
      if (pend.size() == 0) begin
        if (d == 8'hF0 || d == 8'hE0) pend.push_back(d);
        else if (d == CLR) m_mask = '0;
        else if (k >= 0) m_mask[k] = 1'b1;
      end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
        if (d == 8'hF0 || d == 8'hE0) m_err = 1'b1;
        else if (k >= 0) m_mask[k] = 1'b0;
        pend.delete();
      end else if (pend.size() == 1 && d == 8'hF0) begin
        pend.push_back(d);
      end else begin
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        m_err = 1'b1; pend.delete(); idle_cnt = 0;
      end
    end
    m_chg = (m_mask != old);
  endtask

  task automatic apply(input bit c, input bit v, input logic [7:0] d);
    @(negedge clk);
    clear = c; rx_valid = v; rx_data = d;
    @(posedge clk);
    model_step(c, v, d);
    #1;
  endtask

  task automatic check_main(input string name, input logic [3:0] em, input logic [2:0] ec,
                            input logic ech, input logic eer);
    vectors++;
    if ({mask, cnt, chg, err} !== {em, ec, ech, eer}) begin
      miscompares++;
      $display("FAIL %s: got mask=%b cnt=%0d chg=%b err=%b, expected mask=%b cnt=%0d chg=%b err=%b",
               name, mask, cnt, chg, err, em, ec, ech, eer);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sweep_step(input bit a1, input logic [7:0] b1, input bit a8,
                            input logic [7:0] b8);
    @(negedge clk);
    v1 = a1; d1 = b1; v8 = a8; d8 = b8;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         c;
    bit         v;
    logic [7:0] d;
    logic [3:0] em;
    logic [2:0] ec;
    bit         ech;
    bit         eer;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] keys8[8] = '{8'h43, 8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15};

  initial begin
    tbl = '{
      '{0, 1, 8'h1C, 4'b0001, 3'd1, 1, 0}, '{0, 1, 8'h1B, 4'b0011, 3'd2, 1, 0},
      '{0, 1, 8'h23, 4'b0111, 3'd3, 1, 0}, '{0, 1, 8'h2B, 4'b1111, 3'd4, 1, 0},
      '{1, 0, 8'h00, 4'b0000, 3'd0, 1, 0}, '{0, 1, 8'h1C, 4'b0001, 3'd1, 1, 0},
      '{0, 1, 8'h1C, 4'b0001, 3'd1, 0, 0}, '{0, 1, 8'h1C, 4'b0001, 3'd1, 0, 0},
      '{0, 1, 8'hF0, 4'b0001, 3'd1, 0, 0}, '{0, 1, 8'h1C, 4'b0000, 3'd0, 1, 0},
      '{0, 1, 8'hE0, 4'b0000, 3'd0, 0, 0}, '{0, 1, 8'h1C, 4'b0000, 3'd0, 0, 0},
      '{0, 1, 8'h1B, 4'b0010, 3'd1, 1, 0}, '{0, 1, 8'hF0, 4'b0010, 3'd1, 0, 0},
      '{0, 1, 8'h1C, 4'b0010, 3'd1, 0, 0}, '{0, 1, 8'h1C, 4'b0011, 3'd2, 1, 0},
      '{0, 1, 8'h2B, 4'b1011, 3'd3, 1, 0}, '{0, 1, 8'h29, 4'b0000, 3'd0, 1, 0},
      '{1, 1, 8'h1C, 4'b0000, 3'd0, 0, 0}, '{0, 0, 8'h1C, 4'b0000, 3'd0, 0, 0},
      '{0, 1, 8'hF0, 4'b0000, 3'd0, 0, 0}, '{0, 1, 8'hF0, 4'b0000, 3'd0, 0, 1},
      '{0, 1, 8'h1C, 4'b0001, 3'd1, 1, 0}, '{0, 1, 8'hE0, 4'b0001, 3'd1, 0, 0},
      '{0, 1, 8'hF0, 4'b0001, 3'd1, 0, 0}, '{0, 1, 8'h1C, 4'b0001, 3'd1, 0, 0},
      '{0, 1, 8'hF0, 4'b0001, 3'd1, 0, 0}, '{0, 1, 8'hE0, 4'b0001, 3'd1, 0, 1},
      '{0, 1, 8'h1B, 4'b0011, 3'd2, 1, 0}
    };

    reset = 1'b1; clear = 1'b0; rx_valid = 1'b0; rx_data = '0;
    v1 = 1'b0; d1 = '0; v8 = 1'b0; d8 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].c, tbl[i].v, tbl[i].d);
      check_main($sformatf("table[%0d]", i), tbl[i].em, tbl[i].ec, tbl[i].ech, tbl[i].eer);
    end

    // Prefix timeout, then the next byte must be a make.
    apply(1'b1, 1'b0, 8'h00);
    check_main("to_clear", 4'b0000, 3'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 8'hF0);
    for (int i = 1; i <= TO; i++) begin
      apply(1'b0, 1'b0, 8'h1C);
      check_main($sformatf("timeout[%0d]", i), 4'b0000, 3'd0, 1'b0, i == TO);
    end
    apply(1'b0, 1'b0, 8'h00);
    check_main("timeout_after", 4'b0000, 3'd0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 8'h1C);
    check_main("make_after_to", 4'b0001, 3'd1, 1'b1, 1'b0);

    // Reset in the middle of a break abandons it.
    apply(1'b0, 1'b1, 8'hF0);
    @(negedge clk);
    rx_valid = 1'b0; reset = 1'b1;
    #1;
    model_reset();
    check_main("async_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b1, 8'h1B);
    apply(1'b0, 1'b1, 8'h1C);
    check_main("after_reset", 4'b0011, 3'd2, 1'b1, 1'b0);

    // Randomized traffic: dense and sparse phases so timeouts also occur.
    for (int i = 0; i < 1200; i++) begin
      bit c, v;
      logic [7:0] d;
      int sel;
      c = ($urandom % 40) == 0;
      v = (i % 400 < 250) ? (($urandom % 4) != 0) : (($urandom % 12) == 0);
      sel = $urandom % 10;
      if (sel < 5) d = keys[$urandom % 4];
      else if (sel == 5) d = 8'hF0;
      else if (sel == 6) d = 8'hE0;
      else if (sel == 7) d = CLR;
      else d = 8'($urandom);
      apply(c, v, d);
      check_main($sformatf("random[%0d]", i), m_mask, 3'($countones(m_mask)), m_chg, m_err);
    end
    @(negedge clk);
    rx_valid = 1'b0; clear = 1'b0;

    // Parameter sweep: N_CH=1.
    sweep_step(1'b1, 8'h1C, 1'b0, 8'h00);
    check_val("n1_make", {mask1, cnt1, chg1}, {1'b1, 1'b1, 1'b1});
    sweep_step(1'b1, 8'hF0, 1'b0, 8'h00);
    sweep_step(1'b1, 8'h1C, 1'b0, 8'h00);
    check_val("n1_break", {mask1, cnt1, chg1}, {1'b0, 1'b0, 1'b1});

    // Parameter sweep: N_CH=8, all keys down.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] em;
      em = 8'((16'd1 << (i + 1)) - 16'd1);
      sweep_step(1'b0, 8'h00, 1'b1, keys8[i]);
      check_val($sformatf("n8_press[%0d]", i), {mask8, cnt8, chg8},
                {em, 4'(i + 1), 1'b1});
    end
    sweep_step(1'b0, 8'h00, 1'b1, 8'hF0);
    check_val("n8_f0", {err8, cnt8}, {1'b0, 4'd8});
    sweep_step(1'b0, 8'h00, 1'b1, 8'hF0);
    check_val("n8_f0f0_err", {err8, cnt8}, {1'b1, 4'd8});
    sweep_step(1'b0, 8'h00, 1'b1, 8'h15);
    check_val("n8_make_after_err", {mask8, cnt8, chg8, err8}, {8'hFF, 4'd8, 1'b0, 1'b0});
    sweep_step(1'b0, 8'h00, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_sensor_tracker.md
# ps2_sensor_tracker

Parametrised key-to-sensor state tracker. It consumes decoded PS/2 set-2 scan-code bytes from the keyboard receiver and maintains a per-channel "sensor active" mask. The block handles make, break (F0), extended (E0) and clear-key sequences, and keeps an exact active-channel count. It sits directly after the PS/2 receiver and drives the sensor-emulation outputs of the system.

## Interface
Parameters:
- N_CH, 4, number of sensor channels (1..8).
- KEY_CODES, {8'h2B,8'h23,8'h1B,8'h1C}, packed N_CH×8 scan codes. Channel i uses bits [8i+7:8i]. Defaults map A→ch0, S→ch1, D→ch2, F→ch3.
- CLR_CODE, 8'h29, make code that clears all channels (space).
- TO_CYCLES, 1_000_000, prefix timeout in clk cycles (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  scan-code byte.
- clear  in  1  synchronous clear of mask and sequencer.
- sensor_mask  out  N_CH  bit i = 1 while channel i's key is held.
- active_count  out  CW = $clog2(N_CH+1)  popcount of sensor_mask.
- changed  out  1  one-cycle pulse when sensor_mask changes.
- seq_err  out  1  one-cycle pulse on prefix timeout or a malformed sequence.

Reset is asynchronous, active-high, on `reset`. The clock is `clk`.

## Operation
- Sequencer states:
  - IDLE: normal byte handling.
  - BRK: an F0 was received.
  - EXT: an E0 was received.
  - EXT_BRK: E0 followed by F0.
- IDLE:
  - F0 → BRK.
  - E0 → EXT.
  - CLR_CODE → mask := 0.
  - Byte matching KEY_CODES[i] → set bit i.
  - Any other byte is ignored.
- BRK:
  - Byte matching KEY_CODES[i] → clear bit i, then → IDLE.
  - Any other non-prefix byte → IDLE with no mask change.
  - F0 or E0 received in BRK → seq_err, → IDLE, byte dropped.
- EXT:
  - F0 → EXT_BRK.
  - Any other byte → IDLE. Extended keys never touch the mask, even if the low byte matches a key code.
- EXT_BRK: any byte → IDLE, mask unchanged.
- Key matching:
  - Lowest matching index only if KEY_CODES has duplicates.
  - A make on a set bit (typematic repeat) is a no-op.
  - A break on a clear bit is a no-op.
  - changed is not pulsed for no-ops.
- active_count:
  - Always equals popcount(sensor_mask) in the same cycle. Either compute it combinationally from the mask register, or register it alongside the mask.
  - Range 0..N_CH. It never wraps or underflows.
- Prefix timeout:
  - A counter loads 0 on entry to any non-IDLE state and increments each cycle without rx_valid.
  - When it reaches TO_CYCLES-1: → IDLE, seq_err pulse.
  - The counter holds in IDLE.
- clear:
  - Mask := 0, state := IDLE, counter := 0.
  - changed pulses only if the mask was nonzero.
  - Has priority over rx_valid in the same cycle; that byte is discarded.

## Timing
- Reset values: sensor_mask=0, active_count=0, changed=0, seq_err=0, state IDLE, counter 0.
- Latency: a byte sampled with rx_valid at edge k updates sensor_mask/active_count, visible after edge k.
- changed and seq_err are registered. Each is high for exactly the one cycle in which the new mask (or the error condition) is first visible.
- Back-to-back rx_valid on consecutive cycles is fully supported, one byte per cycle, with no back-pressure.
- Reset asserted mid-sequence (e.g. in BRK) abandons the sequence. The first byte after release is interpreted from IDLE.
- Only rx_valid-qualified bytes are evaluated. rx_data is don't-care otherwise.

## Test plan
- Make sequence: bytes 1C, 1B, 23, 2B → mask 0001, 0011, 0111, 1111; count 1, 2, 3, 4; changed pulses four times.
- Repeat and release: 1C, 1C, 1C, F0 1C → mask 0001 held through the repeats, changed once; after the break mask=0000, count 0, second changed pulse.
- Extended and break no-ops: E0 1C → mask unchanged. With mask=0010, F0 1C → mask stays 0010, no changed pulse.
- Clear key: mask 1011 then 29 → mask 0000, count 0. Then assert clear and rx_valid (byte 1C) in the same cycle → mask stays 0000, byte discarded.
- Timeout: F0 then silence for TO_CYCLES cycles → seq_err pulse, state IDLE. A following 1C sets bit0 (a make, not a break).
- Parameter sweep: N_CH=1 and N_CH=8 with a custom KEY_CODES → count width 1 and 4. Pressing all 8 keys gives count 8. F0 F0 gives a seq_err pulse.
